uart_host_ctrl: RTL and testbench
=================================

Name: uart_host_ctrl

Overview:
- Register-bus master for the uart_16750 8-bit CPU port (cs/wr/rd/a/din/dout).
- After reset, runs a fixed init sequence: baud divisor, 8N1 line format, FIFO enable, IER.
- Then loops: poll LSR, move one byte per poll between the UART and two valid/ready streams (TX in, RX out), alternating fairly when both can proceed.
- Instantiated in the UART clock domain, beside uart_16750, in place of ad-hoc top-level sequencing.

Parameters:
- DIVISOR, 16'd17, baud divisor written to DLL (low byte) and DLM (high byte).
- LCR_VAL, 8'h03, final LCR value (DLAB cleared).
- FCR_VAL, 8'h81, FCR value.
- IER_VAL, 8'h00, IER value.

Ports:
- clk  in  1  UART domain clock.
- rst  in  1  reset; synchronous, active-high.
- uart_cs  out  1  chip select to uart_16750.
- uart_wr  out  1  write strobe.
- uart_rd  out  1  read strobe.
- uart_addr  out  3  register address.
- uart_din  out  8  write data to the UART.
- uart_dout  in  8  read data from the UART.
- tx_data  in  8  byte to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  tx byte accepted this cycle.
- rx_data  out  8  received byte.
- rx_valid  out  1  rx_data valid.
- rx_ready  in  1  consumer accepts rx_data.
- init_done  out  1  init sequence complete.
- lsr_err  out  1  sticky OR of LSR bits 4:1 (OE/PE/FE/BI).

Behaviour:
- Reset (rst=1 at a rising edge): all outputs 0; FSM returns to INIT_LCR_DLAB; RX buffer emptied; lsr_err cleared. Reset mid-access aborts it; cs/wr/rd are 0 the cycle after the reset edge.
- Bus access is three registered phases:
  - SETUP: cs=1, addr/din valid, wr=rd=0.
  - STROBE: wr or rd=1.
  - RELEASE: cs=wr=rd=0.
  - uart_dout is sampled on the edge that ends STROBE. Every access therefore has cs=0 for at least one cycle.
- States and writes:
  - INIT_LCR_DLAB: write (3, 8'h83).
  - INIT_DLL: write (0, DIVISOR[7:0]).
  - INIT_DLM: write (1, DIVISOR[15:8]).
  - INIT_LCR: write (3, LCR_VAL).
  - INIT_FCR: write (2, FCR_VAL).
  - INIT_IER: write (1, IER_VAL).
  - POLL_LSR: read (5).
  - RD_RBR: read (0).
  - WR_THR: write (0, latched tx byte).
- Init timing: cs first rises on edge 1 after rst deasserts. init_done rises on edge 18, together with the last RELEASE, and stays 1 until reset. POLL_LSR SETUP follows at edge 19.
- Decision, made at the RELEASE cycle of each LSR read:
  - rx_elig = LSR[0] & ~rx_valid.
  - tx_elig = LSR[5] & tx_valid.
  - If both are eligible, pick the opposite of the last data access (rr bit, reset value selects RX first). Otherwise pick the eligible one; if neither, re-poll LSR.
- TX selected: tx_ready=1 for exactly that RELEASE cycle. tx_data is latched into uart_din at that edge, then the WR_THR access runs. tx_ready is 0 at all other times. tx_data need not be held after acceptance.
- RX selected: RD_RBR runs. rx_data <= uart_dout and rx_valid <= 1 at the end of STROBE.
  - rx_valid clears on the edge where rx_valid & rx_ready.
  - rx_data is held stable while rx_valid=1.
  - A full RX buffer blocks RBR reads; the UART FIFO absorbs the backlog.
- After RD_RBR or WR_THR, return to POLL_LSR. Exactly one data access per LSR poll.
- lsr_err: set at any LSR sample with |LSR[4:1]; cleared only by rst.

Optional Feature:
- Macro: UART_HOST_CTRL_LOOPBACK_EN.
- Defined: INIT_MCR state after INIT_IER writes (4, 8'h10), enabling internal loopback. init_done moves to edge 21.
- Undefined: MCR is never written; init_done at edge 18.

Decomposition:
- Package uart_host_pkg holds:
  - register address constants (RBR/THR/DLL=0, IER/DLM=1, FCR=2, LCR=3, MCR=4, LSR=5);
  - LSR bit indices (DR=0, OE=1, THRE=5);
  - LCR_DLAB_SET=8'h83, MCR_LOOP=8'h10;
  - the state enumeration.
- Sub-module uart_bus_cycle: SETUP/STROBE/RELEASE phase engine.
  - Inputs: start, is_write, addr, wdata.
  - Outputs: bus pins, rdata, done pulse in RELEASE.
- The top FSM sequences it.

Test Plan:
- Init, macro off, DIVISOR=17: write log is exactly (3,83),(0,11),(1,00),(3,03),(2,81),(1,00); init_done first high at edge 18; no reads before it.
- TX: model LSR=8'h60, tx_valid=1, tx_data=8'h41 -> tx_ready one cycle, then write (0,41); tx_valid held -> next poll writes again; tx_ready never high outside an LSR RELEASE cycle.
- RX with back-pressure: LSR=8'h61, RBR=8'h20, rx_ready=0 -> rx_valid=1, rx_data=8'h20 held; subsequent polls issue no addr-0 reads until rx_ready=1 for one cycle.
- Fairness: LSR=8'h61, tx_valid=1, rx_ready=1 continuously -> data accesses alternate RD, WR, RD, WR starting with RD.
- Error and reset: LSR=8'h63 once -> lsr_err=1 stays high; assert rst during a STROBE cycle -> next cycle all outputs 0, init sequence restarts from (3,83).
- Macro on: init log ends with (4,10); init_done at edge 21.

Source files
------------

// File: rtl/uart_host_ctrl_pkg.sv
// uart_host_pkg: shared constants for the uart_16750 host controller.
//   - uart_16750 register addresses and LSR bit positions
//   - fixed init values (DLAB set, loopback MCR)
//   - controller state and bus-phase encodings
//   - bus_access_t plus wr_acc/rd_acc helpers to describe one register access
package uart_host_pkg;

  localparam logic [2:0] ADDR_RBR = 3'd0;
  localparam logic [2:0] ADDR_THR = 3'd0;
  localparam logic [2:0] ADDR_DLL = 3'd0;
  localparam logic [2:0] ADDR_IER = 3'd1;
  localparam logic [2:0] ADDR_DLM = 3'd1;
  localparam logic [2:0] ADDR_FCR = 3'd2;
  localparam logic [2:0] ADDR_LCR = 3'd3;
  localparam logic [2:0] ADDR_MCR = 3'd4;
  localparam logic [2:0] ADDR_LSR = 3'd5;

  localparam int LSR_DR   = 0;
  localparam int LSR_OE   = 1;
  localparam int LSR_THRE = 5;

  localparam logic [7:0] LCR_DLAB_SET = 8'h83;
  localparam logic [7:0] MCR_LOOP     = 8'h10;

  // Controller states; each state names the register access it performs.
  localparam logic [3:0] ST_INIT_LCR_DLAB = 4'd0;
  localparam logic [3:0] ST_INIT_DLL      = 4'd1;
  localparam logic [3:0] ST_INIT_DLM      = 4'd2;
  localparam logic [3:0] ST_INIT_LCR      = 4'd3;
  localparam logic [3:0] ST_INIT_FCR      = 4'd4;
  localparam logic [3:0] ST_INIT_IER      = 4'd5;
  localparam logic [3:0] ST_INIT_MCR      = 4'd6;
  localparam logic [3:0] ST_POLL_LSR      = 4'd7;
  localparam logic [3:0] ST_RD_RBR        = 4'd8;
  localparam logic [3:0] ST_WR_THR        = 4'd9;

  // Bus-cycle phases.
  localparam logic [1:0] PH_IDLE    = 2'd0;
  localparam logic [1:0] PH_SETUP   = 2'd1;
  localparam logic [1:0] PH_STROBE  = 2'd2;
  localparam logic [1:0] PH_RELEASE = 2'd3;

  typedef struct packed {
    logic       write;
    logic [2:0] addr;
    logic [7:0] wdata;
  } bus_access_t;

  function automatic bus_access_t wr_acc(input logic [2:0] a, input logic [7:0] d);
    bus_access_t r;
    r.write = 1'b1;
    r.addr  = a;
    r.wdata = d;
    return r;
  endfunction

  function automatic bus_access_t rd_acc(input logic [2:0] a);
    bus_access_t r;
    r.write = 1'b0;
    r.addr  = a;
    r.wdata = 8'h00;
    return r;
  endfunction

endpackage

// File: rtl/uart_host_ctrl_if.sv
// uart_host_ctrl_if: uart_16750 8-bit CPU port.
//   uart_cs/uart_wr/uart_rd  chip select and strobes (host -> UART)
//   uart_addr[2:0]           register address
//   uart_din[7:0]            write data (host -> UART)
//   uart_dout[7:0]           read data (UART -> host)
// master modport is the host controller side, slave modport the UART side.
interface uart_host_ctrl_if;
  logic       uart_cs;
  logic       uart_wr;
  logic       uart_rd;
  logic [2:0] uart_addr;
  logic [7:0] uart_din;
  logic [7:0] uart_dout;

  modport master (output uart_cs, output uart_wr, output uart_rd,
                  output uart_addr, output uart_din, input uart_dout);
  modport slave  (input uart_cs, input uart_wr, input uart_rd,
                  input uart_addr, input uart_din, output uart_dout);
endinterface

// File: rtl/uart_host_ctrl_bus_cycle.sv
// uart_bus_cycle: three-phase register access engine for the uart_16750 port.
//   start/is_write/addr/wdata  next access, accepted when idle or in RELEASE
//   rdata                      uart_dout captured on the edge ending STROBE
//   done                       high during RELEASE
//   strobe                     high during STROBE (uart_dout is being sampled)
//   bus                        uart_host_ctrl_if master modport (all pins registered)
// Phases: SETUP (cs, addr/din valid) -> STROBE (wr or rd) -> RELEASE (all low).
// A new access may start from RELEASE, so back-to-back accesses take 3 cycles.
module uart_bus_cycle
  import uart_host_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       is_write,
  input  logic [2:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       done,
  output logic       strobe,
  uart_host_ctrl_if.master bus
);

  logic [1:0] phase_q, phase_d;
  logic       cs_q, cs_d, wr_q, wr_d, rd_q, rd_d, is_wr_q, is_wr_d;
  logic [2:0] addr_q, addr_d;
  logic [7:0] din_q, din_d, rdata_q, rdata_d;

  always_comb begin
    phase_d = phase_q;
    cs_d    = cs_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    case (phase_q)
      PH_SETUP: begin
        phase_d = PH_STROBE;
        wr_d    = is_wr_q;
        rd_d    = ~is_wr_q;
      end
      PH_STROBE: begin
        phase_d = PH_RELEASE;
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        rdata_d = bus.uart_dout;
      end
      default: begin
        if (start) begin
          phase_d = PH_SETUP;
          cs_d    = 1'b1;
          is_wr_d = is_write;
          addr_d  = addr;
          din_d   = wdata;
        end else begin
          phase_d = PH_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_IDLE;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      is_wr_q <= 1'b0;
      addr_q  <= 3'd0;
      din_q   <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      phase_q <= phase_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.uart_cs   = cs_q;
  assign bus.uart_wr   = wr_q;
  assign bus.uart_rd   = rd_q;
  assign bus.uart_addr = addr_q;
  assign bus.uart_din  = din_q;
  assign rdata         = rdata_q;
  assign done          = (phase_q == PH_RELEASE);
  assign strobe        = (phase_q == PH_STROBE);

endmodule

// File: rtl/uart_host_ctrl.sv
// uart_host_ctrl: register-bus master for uart_16750.
//   clk, rst           UART-domain clock, synchronous active-high reset
//   bus                uart_host_ctrl_if master (cs/wr/rd/addr/din/dout)
//   tx_data/valid/ready  byte stream into the UART transmitter
//   rx_data/valid/ready  byte stream out of the UART receiver
//   init_done          init sequence finished (sticky until reset)
//   lsr_err            sticky OR of LSR OE/PE/FE/BI
// After reset it writes baud divisor, line format, FCR and IER, then polls LSR
// and moves at most one byte per poll, alternating RX/TX when both can go.
// Build option UART_HOST_CTRL_LOOPBACK_EN: add an MCR write enabling loopback.
module uart_host_ctrl
  import uart_host_pkg::*;
#(
  parameter logic [15:0] DIVISOR = 16'd17,
  parameter logic [7:0]  LCR_VAL = 8'h03,
  parameter logic [7:0]  FCR_VAL = 8'h81,
  parameter logic [7:0]  IER_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  uart_host_ctrl_if.master bus,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       init_done,
  output logic       lsr_err
);

`ifdef UART_HOST_CTRL_LOOPBACK_EN
  localparam logic [3:0] LAST_INIT = ST_INIT_MCR;
`else
  localparam logic [3:0] LAST_INIT = ST_INIT_IER;
`endif

  logic [3:0]  state_q, state_d;
  logic        rr_q, rr_d;            // 1: last data access was RX
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d, lsr_err_q, lsr_err_d, init_done_q, init_done_d;
  logic        done, strobe, rx_elig, tx_elig, tx_ready_c;
  logic [7:0]  rdata;
  bus_access_t acc;

  // State advance happens in RELEASE so the next access launches with no gap.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    tx_ready_c = 1'b0;
    rx_elig    = rdata[LSR_DR] & ~rx_valid_q;
    tx_elig    = rdata[LSR_THRE] & tx_valid;
    if (done) begin
      case (state_q)
        ST_INIT_LCR_DLAB: state_d = ST_INIT_DLL;
        ST_INIT_DLL:      state_d = ST_INIT_DLM;
        ST_INIT_DLM:      state_d = ST_INIT_LCR;
        ST_INIT_LCR:      state_d = ST_INIT_FCR;
        ST_INIT_FCR:      state_d = ST_INIT_IER;
`ifdef UART_HOST_CTRL_LOOPBACK_EN
        ST_INIT_IER:      state_d = ST_INIT_MCR;
`endif
        ST_POLL_LSR: begin
          if (rx_elig && (!tx_elig || !rr_q)) begin
            state_d = ST_RD_RBR;
            rr_d    = 1'b1;
          end else if (tx_elig) begin
            state_d    = ST_WR_THR;
            rr_d       = 1'b0;
            tx_ready_c = 1'b1;
          end else begin
            state_d = ST_POLL_LSR;
          end
        end
        default:          state_d = ST_POLL_LSR;
      endcase
    end
  end

  // The access launched is always the one for state_d; tx_data is only
  // consumed in the cycle WR_THR is entered, which is the tx_ready cycle.
  always_comb begin
    case (state_d)
      ST_INIT_LCR_DLAB: acc = wr_acc(ADDR_LCR, LCR_DLAB_SET);
      ST_INIT_DLL:      acc = wr_acc(ADDR_DLL, DIVISOR[7:0]);
      ST_INIT_DLM:      acc = wr_acc(ADDR_DLM, DIVISOR[15:8]);
      ST_INIT_LCR:      acc = wr_acc(ADDR_LCR, LCR_VAL);
      ST_INIT_FCR:      acc = wr_acc(ADDR_FCR, FCR_VAL);
      ST_INIT_IER:      acc = wr_acc(ADDR_IER, IER_VAL);
      ST_INIT_MCR:      acc = wr_acc(ADDR_MCR, MCR_LOOP);
      ST_RD_RBR:        acc = rd_acc(ADDR_RBR);
      ST_WR_THR:        acc = wr_acc(ADDR_THR, tx_data);
      default:          acc = rd_acc(ADDR_LSR);
    endcase
  end

  // Data-side registers update on the STROBE->RELEASE edge, alongside rdata.
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    lsr_err_d   = lsr_err_q;
    init_done_d = init_done_q;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (strobe) begin
      if (state_q == ST_POLL_LSR) lsr_err_d = lsr_err_q | (|bus.uart_dout[4:LSR_OE]);
      if (state_q == ST_RD_RBR) begin
        rx_data_d  = bus.uart_dout;
        rx_valid_d = 1'b1;
      end
      if (state_q == LAST_INIT) init_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT_LCR_DLAB;
      rr_q        <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      lsr_err_q   <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      lsr_err_q   <= lsr_err_d;
      init_done_q <= init_done_d;
    end
  end

  // The controller always has a next access queued, so start is constant.
  uart_bus_cycle u_bus_cycle (
    .clk      (clk),
    .rst      (rst),
    .start    (1'b1),
    .is_write (acc.write),
    .addr     (acc.addr),
    .wdata    (acc.wdata),
    .rdata    (rdata),
    .done     (done),
    .strobe   (strobe),
    .bus      (bus)
  );

  assign tx_ready  = tx_ready_c;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign lsr_err   = lsr_err_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Self-checking bench for uart_host_ctrl with a behavioural uart_16750 register model.
module tb_uart_host_ctrl;

  localparam logic [15:0] DIV = 16'd17;
`ifdef UART_HOST_CTRL_LOOPBACK_EN
  localparam int INIT_EDGES = 21;
`else
  localparam int INIT_EDGES = 18;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       init_done, lsr_err;
  logic [7:0] lsr_val = 8'h00;
  logic [7:0] rbr_val = 8'h00;

  uart_host_ctrl_if bus ();

  // UART register model: returns LSR/RBR while rd is asserted.
  assign bus.uart_dout = bus.uart_rd ? ((bus.uart_addr == 3'd5) ? lsr_val :
                         (bus.uart_addr == 3'd0) ? rbr_val : 8'h00) : 8'h00;

  uart_host_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .init_done (init_done),
    .lsr_err   (lsr_err)
  );

  int checks = 0;
  int errors = 0;

  logic [10:0] wlog[$];     // {addr, data} of every write strobe
  logic [8:0]  acc_q[$];    // post-init data accesses: {1=WR/0=RD, byte}
  logic [10:0] exp_init[$];
  int rd0_cnt = 0, lsr_reads = 0, txr_bad = 0, rd_early = 0;
  bit lsr_strobe_prev = 1'b0;

  always @(negedge clk) begin
    if (tx_ready && !lsr_strobe_prev) txr_bad++;
    lsr_strobe_prev = bus.uart_rd && (bus.uart_addr == 3'd5);
    if (bus.uart_wr) begin
      wlog.push_back({bus.uart_addr, bus.uart_din});
      if (bus.uart_addr == 3'd0 && init_done) acc_q.push_back({1'b1, bus.uart_din});
    end
    if (bus.uart_rd) begin
      if (!init_done) rd_early++;
      if (bus.uart_addr == 3'd5) lsr_reads++;
      if (bus.uart_addr == 3'd0) begin
        rd0_cnt++;
        acc_q.push_back({1'b0, rbr_val});
      end
    end
  end

  function automatic logic [26:0] outs();
    return {bus.uart_cs, bus.uart_wr, bus.uart_rd, bus.uart_addr, bus.uart_din,
            tx_ready, rx_valid, rx_data, init_done, lsr_err};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    wlog.delete();
    acc_q.delete();
    rd_early = 0;
  endtask

  task automatic wait_init();
    for (int i = 0; i < 100 && !init_done; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if (outs() !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", outs());
    end
  endtask

  task automatic test_init();
    do_reset();
    for (int e = 1; e <= INIT_EDGES + 1; e++) begin
      step();
      if (e == 1) begin
        checks++;
        if (bus.uart_cs !== 1'b1) begin errors++; $display("FAIL init_cs_edge1 got %b want 1", bus.uart_cs); end
      end
      if (e <= INIT_EDGES) begin
        checks++;
        if (init_done !== (e == INIT_EDGES)) begin
          errors++;
          $display("FAIL init_done_edge%0d got %b want %b", e, init_done, (e == INIT_EDGES));
        end
      end else begin
        checks++;
        if (bus.uart_cs !== 1'b1 || bus.uart_addr !== 3'd5 || bus.uart_wr !== 1'b0) begin
          errors++;
          $display("FAIL first_poll_setup got cs=%b addr=%0d wr=%b want cs=1 addr=5 wr=0",
                   bus.uart_cs, bus.uart_addr, bus.uart_wr);
        end
      end
    end
    checks++;
    if (wlog.size() != exp_init.size()) begin
      errors++;
      $display("FAIL init_log_len got %0d want %0d", wlog.size(), exp_init.size());
    end else begin
      for (int i = 0; i < exp_init.size(); i++) begin
        checks++;
        if (wlog[i] !== exp_init[i]) begin
          errors++;
          $display("FAIL init_write%0d got (%0d,%h) want (%0d,%h)", i,
                   wlog[i][10:8], wlog[i][7:0], exp_init[i][10:8], exp_init[i][7:0]);
        end
      end
    end
    checks++;
    if (rd_early != 0) begin errors++; $display("FAIL reads_before_init got %0d want 0", rd_early); end
  endtask

  task automatic test_tx();
    logic [7:0] exp;
    int n;
    bit seen;
    lsr_val  = 8'h60;
    tx_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tx_data = (k == 0) ? 8'h41 : 8'($urandom);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        step();
        seen = tx_ready;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL tx_ready_timeout got 0 want 1"); continue; end
      exp = tx_data;
      n = wlog.size();
      step();
      tx_data = 8'($urandom);  // byte no longer needs to be held
      for (int i = 0; i < 20 && wlog.size() == n; i++) step();
      checks++;
      if (wlog.size() == n || wlog[wlog.size()-1] !== {3'd0, exp}) begin
        errors++;
        $display("FAIL tx_write%0d got (%0d,%h) want (0,%h)", k,
                 (wlog.size() == n) ? 3'd7 : wlog[wlog.size()-1][10:8],
                 (wlog.size() == n) ? 8'h00 : wlog[wlog.size()-1][7:0], exp);
      end
    end
    tx_valid = 1'b0;
    lsr_val  = 8'h00;
    repeat (10) step();
    checks++;
    if (txr_bad != 0) begin errors++; $display("FAIL tx_ready_outside_lsr_release got %0d want 0", txr_bad); end
  endtask

  task automatic test_rx_backpressure();
    logic [7:0] r1, r2;
    int c0, l0;
    r1 = 8'($urandom);
    r2 = r1 ^ 8'hA5;
    rx_ready = 1'b0;
    rbr_val  = r1;
    lsr_val  = 8'h61;
    for (int i = 0; i < 100 && !rx_valid; i++) step();
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== r1) begin
      errors++;
      $display("FAIL rx_first got valid=%b data=%h want valid=1 data=%h", rx_valid, rx_data, r1);
    end
    rbr_val = r2;
    c0 = rd0_cnt;
    l0 = lsr_reads;
    repeat (40) step();
    checks++;
    if (rd0_cnt != c0 || lsr_reads <= l0) begin
      errors++;
      $display("FAIL rx_blocked got rbr_reads=%0d polls=%0d want rbr_reads=0 polls>0", rd0_cnt - c0, lsr_reads - l0);
    end
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== r1) begin
      errors++;
      $display("FAIL rx_held got valid=%b data=%h want valid=1 data=%h", rx_valid, rx_data, r1);
    end
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_consume got %b want 0", rx_valid); end
    for (int i = 0; i < 100 && !rx_valid; i++) step();
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== r2) begin
      errors++;
      $display("FAIL rx_second got valid=%b data=%h want valid=1 data=%h", rx_valid, rx_data, r2);
    end
    lsr_val  = 8'h00;
    rx_ready = 1'b1;
    repeat (5) step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] t, r;
    t = 8'($urandom);
    r = 8'($urandom);
    do_reset();
    wait_init();
    lsr_val  = 8'h61;
    tx_valid = 1'b1;
    tx_data  = t;
    rbr_val  = r;
    rx_ready = 1'b1;
    for (int i = 0; i < 300 && acc_q.size() < 8; i++) step();
    checks++;
    if (acc_q.size() < 8) begin
      errors++;
      $display("FAIL fair_count got %0d want 8", acc_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (acc_q[i] !== ((i % 2 == 1) ? {1'b1, t} : {1'b0, r})) begin
          errors++;
          $display("FAIL fair_access%0d got %h want %h", i, acc_q[i], (i % 2 == 1) ? {1'b1, t} : {1'b0, r});
        end
      end
    end
    tx_valid = 1'b0;
    lsr_val  = 8'h00;
    repeat (10) step();
  endtask

  task automatic test_error_reset();
    int l0;
    bit hit;
    rx_ready = 1'b1;
    checks++;
    if (lsr_err !== 1'b0) begin errors++; $display("FAIL lsr_err_pre got %b want 0", lsr_err); end
    l0 = lsr_reads;
    lsr_val = 8'h63;
    for (int i = 0; i < 20 && lsr_reads == l0; i++) step();
    lsr_val = 8'h60;
    repeat (20) step();
    checks++;
    if (lsr_err !== 1'b1) begin errors++; $display("FAIL lsr_err_sticky got %b want 1", lsr_err); end
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      hit = bus.uart_wr | bus.uart_rd;
    end
    rst = 1'b1;
    step();
    checks++;
    if (outs() !== 27'd0) begin errors++; $display("FAIL reset_mid_strobe got %h want 0", outs()); end
    rst = 1'b0;
    wlog.delete();
    for (int i = 0; i < 10 && wlog.size() == 0; i++) step();
    checks++;
    if (wlog.size() == 0 || wlog[0] !== {3'd3, 8'h83}) begin
      errors++;
      $display("FAIL restart_first_write got %h want %h", (wlog.size() == 0) ? 11'h0 : wlog[0], {3'd3, 8'h83});
    end
    checks++;
    if (lsr_err !== 1'b0) begin errors++; $display("FAIL lsr_err_after_reset got %b want 0", lsr_err); end
  endtask

  initial begin
    exp_init = '{{3'd3, 8'h83}, {3'd0, DIV[7:0]}, {3'd1, DIV[15:8]},
                 {3'd3, 8'h03}, {3'd2, 8'h81}, {3'd1, 8'h00}};
`ifdef UART_HOST_CTRL_LOOPBACK_EN
    exp_init.push_back({3'd4, 8'h10});
`endif
    test_reset();
    test_init();
    test_tx();
    test_rx_backpressure();
    test_back_to_back();
    test_error_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
